// File: rtl/led_pattern_sequencer.sv
// Status-LED blink sequencer: on/off/repeat commands in prescaler ticks over valid/ready.
// Define LED_SEQ_QUEUE_EN to add a 2-entry command queue that chains patterns back to back.
module led_pattern_sequencer #(
   parameter int TICK_DIV = 40000,
   parameter int CNT_W    = 16,
   parameter int REP_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_on_ticks,
   input  logic [CNT_W-1:0] cmd_off_ticks,
   input  logic [REP_W-1:0] cmd_repeat,
   input  logic             abort,
   output logic             led,
   output logic             busy,
   output logic             done
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef struct packed {
      logic [CNT_W-1:0] on;
      logic [CNT_W-1:0] off;
      logic [REP_W-1:0] rep;
   } cmd_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   cmd_t             cur_q;
   logic             done_d;
   logic             load;

   cmd_t             in_cmd;
   cmd_t             src;
   logic             src_avail;
   logic             chain_ok;

   logic             tick;
   logic [CNT_W-1:0] cur_len;
   logic             phase_end;
   logic [REP_W-1:0] rep_dec;

   assign in_cmd = {cmd_on_ticks, cmd_off_ticks, cmd_repeat};

`ifdef LED_SEQ_QUEUE_EN
   cmd_t       q_mem [2];
   logic [1:0] q_cnt;
   logic [1:0] q_base;
   logic       push;
   logic       flush;

   assign cmd_ready = !rst && (q_cnt != 2'd2);
   assign push      = cmd_valid && cmd_ready;
   assign flush     = abort && (state_q != ST_IDLE);
   assign src       = q_mem[0];
   assign src_avail = (q_cnt != 2'd0);
   // A zero-length head is not chained; IDLE pops it next cycle so its done stays distinct.
   assign chain_ok  = src_avail && ((src.on != '0) || (src.off != '0));
   assign q_base    = q_cnt - {1'b0, load};

   always_ff @(posedge clk) begin
      if (rst) begin
         q_cnt <= '0;
      end else if (flush) begin
         q_cnt <= {1'b0, push};
         if (push) q_mem[0] <= in_cmd;
      end else begin
         if (load) q_mem[0] <= q_mem[1];
         if (push) q_mem[q_base[0]] <= in_cmd;
         q_cnt <= q_base + {1'b0, push};
      end
   end
`else
   assign cmd_ready = !rst && (state_q == ST_IDLE);
   assign src       = in_cmd;
   assign src_avail = cmd_valid;
   assign chain_ok  = 1'b0;
`endif

   assign tick      = (presc_q == PRESC_MAX);
   assign cur_len   = (state_q == ST_ON) ? cur_q.on : cur_q.off;
   assign phase_end = tick && (phase_q == cur_len - 1'b1);
   assign rep_dec   = rep_cnt_q - 1'b1;

   always_comb begin
      state_d   = state_q;
      presc_d   = tick ? '0 : presc_q + 1'b1;
      phase_d   = phase_q;
      rep_cnt_d = rep_cnt_q;
      done_d    = 1'b0;
      load      = 1'b0;
      unique case (state_q)
         ST_IDLE: load = src_avail;
         ST_ON, ST_OFF: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (phase_end) begin
               phase_d = '0;
               if (state_q == ST_ON && cur_q.off != '0) begin
                  state_d = ST_OFF;
               end else if (cur_q.rep != '0 && rep_dec == '0) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                  load    = chain_ok;
               end else begin
                  // repeat=0 runs forever, so its counter is left untouched
                  rep_cnt_d = (cur_q.rep != '0) ? rep_dec : rep_cnt_q;
                  state_d   = (cur_q.on != '0) ? ST_ON : ST_OFF;
               end
            end else if (tick) begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         presc_d   = '0;
         phase_d   = '0;
         rep_cnt_d = src.rep;
         if (src.on != '0) begin
            state_d = ST_ON;
         end else if (src.off != '0) begin
            state_d = ST_OFF;
         end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         phase_q   <= '0;
         rep_cnt_q <= '0;
         cur_q     <= '0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         phase_q   <= phase_d;
         rep_cnt_q <= rep_cnt_d;
         done      <= done_d;
         if (load) cur_q <= src;
      end
   end

   assign led  = (state_q == ST_ON);
   assign busy = (state_q != ST_IDLE);

endmodule
